midi_msg_decoder: RTL and testbench
===================================

// Module: midi_msg_decoder
// PURPOSE
//  Byte-stream MIDI parser in the synth clock domain (32 MHz). Takes resynchronised UART bytes
//  and emits one-cycle event pulses with decoded channel/note/velocity to the voice engine.
//  Also emits controller commands (SysEx), a synth soft-reset request and a state read-back strobe.
// PARAMETERS
//  SYSEX_ID   7'h7D  manufacturer ID accepted for controller SysEx; other IDs are ignored
// PORTS
//  clk                input   1  system clock, all logic on rising edge
//  rst                input   1  asynchronous, active-high reset
//  valid_byte         input   1  one-cycle strobe: data holds a received byte
//  data               input   8  received MIDI byte
//  note_presse        output  1  pulse: Note On with velocity != 0
//  note_release       output  1  pulse: Note Off, or Note On with velocity 0
//  note_keypress      output  1  pulse: polyphonic key pressure (An)
//  note_channelpress  output  1  pulse: channel pressure (Dn)
//  channel            output  4  channel nibble of the last completed channel message
//  note               output  7  key number of the last note/keypress message
//  velocity           output  7  velocity / pressure value of the last message
//  rst_cmd            output  1  pulse: System Reset byte 0xFF received
//  read               output  1  pulse: read-back request, byte 0xF9 received
//  c_valid            output  1  pulse: controller SysEx command complete
//  c_cmd              output  7  controller command code
//  c_byte0..c_byte2   output  8  controller arguments, {1'b0, data[6:0]}
// BEHAVIOUR
//  - Reset: every output 0; running status cleared (none); parser IDLE.
//  - All outputs registered; event pulses high exactly 1 cycle, on the cycle after the
//    valid_byte that completes the message. valid_byte low: no state change.
//  - Channel status 8n/9n/An/Bn/En expect 2 data bytes; Cn/Dn expect 1. A status byte sets
//    running status and clears the data index; later data bytes (bit7=0) reuse it.
//  - 8n: note_release. 9n: velocity!=0 -> note_presse, else note_release (velocity output 0).
//    An: note_keypress, velocity=pressure. Dn: note_channelpress, note unchanged, velocity=pressure.
//    Bn/Cn/En: parsed and discarded, no pulse, outputs unchanged.
//  - channel/note/velocity update in the same cycle the pulse rises and hold until next event.
//  - Realtime bytes F8..FF are single-byte, never alter running status nor a partial message.
//    0xFF -> rst_cmd pulse; 0xF9 -> read pulse; others ignored.
//  - F1..F7 (except F0) and F4/F5: clear running status; following data bytes ignored until the
//    next status byte (F1/F2/F3 payloads skipped the same way).
//  - SysEx: F0, ID, cmd, b0, b1, b2, F7. ID==SYSEX_ID and exactly 4 bytes after ID ->
//    c_valid pulse on the F7 cycle, c_cmd/c_byte* latched then. Wrong ID, wrong count or any
//    non-realtime status interrupting it -> silently aborted. Running status cleared after F0.
//  - Data byte with no running status: ignored.
//  - Status byte mid-message: partial message dropped, new status starts.
//  - Async rst mid-message: partial message and running status discarded, outputs to 0.
// TESTING
//  90 3C 64 -> note_presse 1 cycle, channel=0, note=0x3C, velocity=0x64.
//  93 40 7F then 41 00 (running) -> note_presse ch3 0x40/0x7F, then note_release note=0x41 vel=0.
//  90 3C, FF, 50 -> rst_cmd pulse, then note_presse note=0x3C vel=0x50 (realtime transparent).
//  D2 30 then A1 22 11 -> note_channelpress ch2 vel=0x30; note_keypress ch1 note=0x22 vel=0x11.
//  F0 7D 05 01 02 03 F7 -> c_valid, c_cmd=5, c_byte0..2=01/02/03; with ID 7E -> no c_valid.
//  F9 -> read pulse; 90 3C 80 45 -> status 80 aborts, 80 45 incomplete, no pulse until 2nd data.

Source files
------------

// File: rtl/midi_msg_decoder.sv
// MIDI byte-stream parser: channel voice messages with running status,
// realtime reset/read-back strobes and a single-ID controller SysEx.
module midi_msg_decoder #(
    parameter logic [6:0] SYSEX_ID = 7'h7D
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_byte,
    input  logic [7:0] data,
    output logic       note_presse,
    output logic       note_release,
    output logic       note_keypress,
    output logic       note_channelpress,
    output logic [3:0] channel,
    output logic [6:0] note,
    output logic [6:0] velocity,
    output logic       rst_cmd,
    output logic       read,
    output logic       c_valid,
    output logic [6:0] c_cmd,
    output logic [7:0] c_byte0,
    output logic [7:0] c_byte1,
    output logic [7:0] c_byte2
);

    // ST_IDLE    | no running status, data bytes are ignored
    // ST_CHAN    | running status held in rs_type/rs_chan, collecting data
    // ST_SX_ID   | after F0, waiting for manufacturer ID
    // ST_SX_BODY | ID matched, collecting cmd + 3 argument bytes
    // ST_SX_DROP | SysEx rejected, swallowing bytes until next status
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHAN,
        ST_SX_ID,
        ST_SX_BODY,
        ST_SX_DROP
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] rs_type_q, rs_type_d;
    logic [3:0] rs_chan_q, rs_chan_d;
    logic       idx_q, idx_d;
    logic [6:0] d1_q, d1_d;
    logic [2:0] sx_cnt_q, sx_cnt_d;
    logic [6:0] sx_cmd_q, sx_cmd_d;
    logic [6:0] sx_b0_q, sx_b0_d;
    logic [6:0] sx_b1_q, sx_b1_d;
    logic [6:0] sx_b2_q, sx_b2_d;

    logic       presse_q, presse_d;
    logic       release_q, release_d;
    logic       keypress_q, keypress_d;
    logic       chanpress_q, chanpress_d;
    logic [3:0] channel_q, channel_d;
    logic [6:0] note_q, note_d;
    logic [6:0] velocity_q, velocity_d;
    logic       rst_cmd_q, rst_cmd_d;
    logic       read_q, read_d;
    logic       c_valid_q, c_valid_d;
    logic [6:0] c_cmd_q, c_cmd_d;
    logic [6:0] c_b0_q, c_b0_d;
    logic [6:0] c_b1_q, c_b1_d;
    logic [6:0] c_b2_q, c_b2_d;

    logic is_rt;
    logic two_byte;
    logic msg_done;

    // Realtime bytes are transparent; Cn/Dn are the only one-data-byte messages.
    always_comb begin
        is_rt    = (data[7:3] == 5'b11111);
        two_byte = (rs_type_q != 4'hC) && (rs_type_q != 4'hD);
        msg_done = two_byte ? idx_q : 1'b1;
    end

    // Parser state and message-assembly registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rs_type_q <= 4'h0;
            rs_chan_q <= 4'h0;
            idx_q     <= 1'b0;
            d1_q      <= 7'h0;
            sx_cnt_q  <= 3'd0;
            sx_cmd_q  <= 7'h0;
            sx_b0_q   <= 7'h0;
            sx_b1_q   <= 7'h0;
            sx_b2_q   <= 7'h0;
        end else begin
            state_q   <= state_d;
            rs_type_q <= rs_type_d;
            rs_chan_q <= rs_chan_d;
            idx_q     <= idx_d;
            d1_q      <= d1_d;
            sx_cnt_q  <= sx_cnt_d;
            sx_cmd_q  <= sx_cmd_d;
            sx_b0_q   <= sx_b0_d;
            sx_b1_q   <= sx_b1_d;
            sx_b2_q   <= sx_b2_d;
        end
    end

    // Next-state: status bytes restart parsing, data bytes advance it.
    always_comb begin
        state_d   = state_q;
        rs_type_d = rs_type_q;
        rs_chan_d = rs_chan_q;
        idx_d     = idx_q;
        d1_d      = d1_q;
        sx_cnt_d  = sx_cnt_q;
        sx_cmd_d  = sx_cmd_q;
        sx_b0_d   = sx_b0_q;
        sx_b1_d   = sx_b1_q;
        sx_b2_d   = sx_b2_q;
        if (valid_byte && !is_rt) begin
            if (data[7]) begin
                idx_d = 1'b0;
                if (data[7:4] != 4'hF) begin
                    state_d   = ST_CHAN;
                    rs_type_d = data[7:4];
                    rs_chan_d = data[3:0];
                end else if (data == 8'hF0) begin
                    state_d  = ST_SX_ID;
                    sx_cnt_d = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end else begin
                case (state_q)
                    ST_CHAN: begin
                        if (!msg_done) begin
                            idx_d = 1'b1;
                            d1_d  = data[6:0];
                        end else begin
                            idx_d = 1'b0;
                        end
                    end
                    ST_SX_ID: begin
                        state_d = (data[6:0] == SYSEX_ID) ? ST_SX_BODY : ST_SX_DROP;
                    end
                    ST_SX_BODY: begin
                        case (sx_cnt_q)
                            3'd0:    sx_cmd_d = data[6:0];
                            3'd1:    sx_b0_d  = data[6:0];
                            3'd2:    sx_b1_d  = data[6:0];
                            3'd3:    sx_b2_d  = data[6:0];
                            default: state_d  = ST_SX_DROP;
                        endcase
                        if (sx_cnt_q != 3'd4) sx_cnt_d = sx_cnt_q + 3'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output decode: one-cycle pulses and held event fields.
    always_comb begin
        presse_d    = 1'b0;
        release_d   = 1'b0;
        keypress_d  = 1'b0;
        chanpress_d = 1'b0;
        rst_cmd_d   = 1'b0;
        read_d      = 1'b0;
        c_valid_d   = 1'b0;
        channel_d   = channel_q;
        note_d      = note_q;
        velocity_d  = velocity_q;
        c_cmd_d     = c_cmd_q;
        c_b0_d      = c_b0_q;
        c_b1_d      = c_b1_q;
        c_b2_d      = c_b2_q;
        if (valid_byte) begin
            if (is_rt) begin
                rst_cmd_d = (data == 8'hFF);
                read_d    = (data == 8'hF9);
            end else if (data == 8'hF7 && state_q == ST_SX_BODY && sx_cnt_q == 3'd4) begin
                c_valid_d = 1'b1;
                c_cmd_d   = sx_cmd_q;
                c_b0_d    = sx_b0_q;
                c_b1_d    = sx_b1_q;
                c_b2_d    = sx_b2_q;
            end else if (!data[7] && state_q == ST_CHAN && msg_done) begin
                case (rs_type_q)
                    4'h8, 4'h9, 4'hA: begin
                        channel_d   = rs_chan_q;
                        note_d      = d1_q;
                        velocity_d  = data[6:0];
                        keypress_d  = (rs_type_q == 4'hA);
                        presse_d    = (rs_type_q == 4'h9) && (data[6:0] != 7'h0);
                        release_d   = (rs_type_q == 4'h8) ||
                                      ((rs_type_q == 4'h9) && (data[6:0] == 7'h0));
                    end
                    4'hD: begin
                        channel_d   = rs_chan_q;
                        velocity_d  = data[6:0];
                        chanpress_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presse_q    <= 1'b0;
            release_q   <= 1'b0;
            keypress_q  <= 1'b0;
            chanpress_q <= 1'b0;
            channel_q   <= 4'h0;
            note_q      <= 7'h0;
            velocity_q  <= 7'h0;
            rst_cmd_q   <= 1'b0;
            read_q      <= 1'b0;
            c_valid_q   <= 1'b0;
            c_cmd_q     <= 7'h0;
            c_b0_q      <= 7'h0;
            c_b1_q      <= 7'h0;
            c_b2_q      <= 7'h0;
        end else begin
            presse_q    <= presse_d;
            release_q   <= release_d;
            keypress_q  <= keypress_d;
            chanpress_q <= chanpress_d;
            channel_q   <= channel_d;
            note_q      <= note_d;
            velocity_q  <= velocity_d;
            rst_cmd_q   <= rst_cmd_d;
            read_q      <= read_d;
            c_valid_q   <= c_valid_d;
            c_cmd_q     <= c_cmd_d;
            c_b0_q      <= c_b0_d;
            c_b1_q      <= c_b1_d;
            c_b2_q      <= c_b2_d;
        end
    end

    assign note_presse       = presse_q;
    assign note_release      = release_q;
    assign note_keypress     = keypress_q;
    assign note_channelpress = chanpress_q;
    assign channel           = channel_q;
    assign note              = note_q;
    assign velocity          = velocity_q;
    assign rst_cmd           = rst_cmd_q;
    assign read              = read_q;
    assign c_valid           = c_valid_q;
    assign c_cmd             = c_cmd_q;
    assign c_byte0           = {1'b0, c_b0_q};
    assign c_byte1           = {1'b0, c_b1_q};
    assign c_byte2           = {1'b0, c_b2_q};

endmodule

// File: tb/tb_midi_msg_decoder.sv
// Self-checking bench for midi_msg_decoder: directed spec scenarios followed by
// random byte streams checked against a message-level reference model.
module tb_midi_msg_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_byte = 1'b0;
    logic [7:0] data = 8'h00;
    logic       note_presse, note_release, note_keypress, note_channelpress;
    logic [3:0] channel;
    logic [6:0] note, velocity;
    logic       rst_cmd, read, c_valid;
    logic [6:0] c_cmd;
    logic [7:0] c_byte0, c_byte1, c_byte2;

    int tests = 0;
    int fails = 0;

    midi_msg_decoder dut (
        .clk(clk), .rst(rst), .valid_byte(valid_byte), .data(data),
        .note_presse(note_presse), .note_release(note_release),
        .note_keypress(note_keypress), .note_channelpress(note_channelpress),
        .channel(channel), .note(note), .velocity(velocity),
        .rst_cmd(rst_cmd), .read(read), .c_valid(c_valid), .c_cmd(c_cmd),
        .c_byte0(c_byte0), .c_byte1(c_byte1), .c_byte2(c_byte2)
    );

    always #5 clk = ~clk;

    // reference model state: message-level view of the stream
    int         m_rs;            // running status byte, -1 = none
    logic [7:0] m_pend[$];       // data bytes of the current channel message
    bit         m_in_sx;
    logic [7:0] m_sx[$];         // bytes following F0
    // expected outputs
    bit         e_pr, e_rl, e_kp, e_cp, e_rc, e_rd, e_cv;
    logic [3:0] e_ch;
    logic [6:0] e_note, e_vel, e_cmd;
    logic [7:0] e_b0, e_b1, e_b2;

    function automatic void model_reset();
        m_rs = -1; m_pend.delete(); m_in_sx = 0; m_sx.delete();
        {e_pr, e_rl, e_kp, e_cp, e_rc, e_rd, e_cv} = '0;
        e_ch = 0; e_note = 0; e_vel = 0; e_cmd = 0; e_b0 = 0; e_b1 = 0; e_b2 = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int hi, need;
        if (b >= 8'hF8) begin
            if (b == 8'hFF) e_rc = 1;
            if (b == 8'hF9) e_rd = 1;
            return;
        end
        if (b[7]) begin
            if (m_in_sx && b == 8'hF7 && m_sx.size() == 5 && m_sx[0] == 8'h7D) begin
                e_cv = 1; e_cmd = m_sx[1][6:0];
                e_b0 = m_sx[2]; e_b1 = m_sx[3]; e_b2 = m_sx[4];
            end
            m_in_sx = 0; m_sx.delete(); m_pend.delete();
            if (b < 8'hF0) m_rs = b;
            else begin
                m_rs = -1;
                if (b == 8'hF0) m_in_sx = 1;
            end
            return;
        end
        if (m_in_sx) begin m_sx.push_back(b); return; end
        if (m_rs < 0) return;
        m_pend.push_back(b);
        hi = m_rs / 16;
        need = (hi == 12 || hi == 13) ? 1 : 2;
        if (m_pend.size() < need) return;
        case (hi)
            8:  begin e_rl = 1; e_ch = m_rs % 16; e_note = m_pend[0][6:0]; e_vel = m_pend[1][6:0]; end
            9:  begin
                    if (m_pend[1] != 0) e_pr = 1; else e_rl = 1;
                    e_ch = m_rs % 16; e_note = m_pend[0][6:0]; e_vel = m_pend[1][6:0];
                end
            10: begin e_kp = 1; e_ch = m_rs % 16; e_note = m_pend[0][6:0]; e_vel = m_pend[1][6:0]; end
            13: begin e_cp = 1; e_ch = m_rs % 16; e_vel = m_pend[0][6:0]; end
            default: ;
        endcase
        m_pend.delete();
    endfunction

    function automatic logic [55:0] dut_vec();
        return {note_presse, note_release, note_keypress, note_channelpress, channel, note,
                velocity, rst_cmd, read, c_valid, c_cmd, c_byte0, c_byte1, c_byte2};
    endfunction

    function automatic logic [55:0] exp_vec();
        return {e_pr, e_rl, e_kp, e_cp, e_ch, e_note, e_vel, e_rc, e_rd, e_cv, e_cmd,
                e_b0, e_b1, e_b2};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drive one cycle at a negedge, check all outputs at the following negedge
    task automatic step(input bit v, input logic [7:0] b);
        valid_byte = v; data = b;
        {e_pr, e_rl, e_kp, e_cp, e_rc, e_rd, e_cv} = '0;
        if (v) model_byte(b);
        @(negedge clk);
        chk($sformatf("outs byte=%h v=%0d", b, v), {8'h0, dut_vec()}, {8'h0, exp_vec()});
        valid_byte = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b);
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 99);
        if (r < 8)  return 8'h00;
        if (r < 50) return 8'($urandom_range(0, 127));
        if (r < 75) return {1'b1, 3'($urandom_range(0, 6)), 4'($urandom_range(0, 15))};
        if (r < 79) return 8'hF0;
        if (r < 82) return 8'h7D;
        if (r < 85) return 8'hF7;
        if (r < 92) return 8'($urandom_range(8'hF8, 8'hFF));
        return 8'($urandom_range(8'hF1, 8'hF6));
    endfunction

    initial begin
        model_reset();
        @(negedge clk);
        chk("reset state", {8'h0, dut_vec()}, 64'h0);
        rst = 1'b0;
        step(1'b0, 8'h00);

        // 90 3C 64
        send(8'h90); send(8'h3C); send(8'h64);
        chk("presse", note_presse, 1); chk("note 3C", note, 7'h3C); chk("vel 64", velocity, 7'h64);
        step(1'b0, 8'h00);
        chk("presse one cycle", note_presse, 0);
        // running status
        send(8'h93); send(8'h40); send(8'h7F);
        chk("ch3", channel, 4'h3);
        send(8'h41); send(8'h00);
        chk("release vel0", {note_release, note, velocity}, {1'b1, 7'h41, 7'h00});
        // realtime transparent
        send(8'h90); send(8'h3C); send(8'hFF);
        chk("rst_cmd", rst_cmd, 1);
        send(8'h50);
        chk("presse after rt", {note_presse, note, velocity}, {1'b1, 7'h3C, 7'h50});
        // channel pressure then key pressure
        send(8'hD2); send(8'h30);
        chk("chanpress", {note_channelpress, channel, velocity}, {1'b1, 4'h2, 7'h30});
        send(8'hA1); send(8'h22); send(8'h11);
        chk("keypress", {note_keypress, channel, note, velocity}, {1'b1, 4'h1, 7'h22, 7'h11});
        // SysEx good and wrong ID
        send(8'hF0); send(8'h7D); send(8'h05); send(8'h01); send(8'h02); send(8'h03); send(8'hF7);
        chk("sysex", {c_valid, c_cmd, c_byte0, c_byte1, c_byte2}, {1'b1, 7'h05, 24'h010203});
        send(8'hF0); send(8'h7E); send(8'h05); send(8'h01); send(8'h02); send(8'h03); send(8'hF7);
        chk("sysex bad id", c_valid, 0);
        send(8'hF0); send(8'h7D); send(8'h05); send(8'h01); send(8'h02); send(8'hF7);
        chk("sysex short", c_valid, 0);
        // read-back, status abort
        send(8'hF9);
        chk("read", read, 1);
        send(8'h90); send(8'h3C); send(8'h80); send(8'h45);
        chk("abort no pulse", {note_presse, note_release}, 2'b00);
        send(8'h46);
        chk("release after abort", {note_release, note, velocity}, {1'b1, 7'h45, 7'h46});
        // system common clears running status
        send(8'hF3); send(8'h10); send(8'h20);
        chk("F3 cleared rs", note_release, 0);

        // async reset mid-message
        send(8'h92); send(8'h33);
        #3 rst = 1'b1;
        #1;
        chk("async rst outs", {8'h0, dut_vec()}, 64'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        send(8'h44); send(8'h55);
        chk("rs gone after rst", note_presse, 0);

        // random streams against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) step(1'b0, 8'($urandom()));
            else if ($urandom_range(0, 49) == 0) begin
                send(8'hF0); send(8'h7D);
                for (int k = 0; k < 4; k++) begin
                    if ($urandom_range(0, 5) == 0) send(8'hF8);
                    send(8'($urandom_range(0, 127)));
                end
                send(8'hF7);
            end else send(rand_byte());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
